// File: rtl/mda_motor_control_ramp_ctrl.sv
// Motor duty-cycle ramp controller.
// Accepts on/duty commands and slews the PWM duty toward the commanded
// target one bounded step at a time. A change of direction is always made
// through a brake dwell at half period, so the motor is never driven
// straight from one direction into the other.
module mda_motor_control_ramp_ctrl #(
    parameter int PERIOD_LENGTH = 16,
    parameter int RAMP_DIV      = 16000,
    parameter int DWELL_CYCLES  = 160000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_on,
    input  logic [PERIOD_LENGTH-1:0] cmd_duty,
    input  logic [PERIOD_LENGTH-1:0] period,
    input  logic [PERIOD_LENGTH-1:0] step,
    output logic                     on,
    output logic [PERIOD_LENGTH-1:0] duty_cycle,
    output logic                     at_target,
    output logic [1:0]               state
);

    localparam int PW = $clog2(RAMP_DIV > 1 ? RAMP_DIV : 2);
    localparam int DW = $clog2(DWELL_CYCLES > 1 ? DWELL_CYCLES : 2);

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        RAMP  = 2'd1,
        DWELL = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic                     on_q, on_d;
    logic [PERIOD_LENGTH-1:0] duty_q, duty_d;
    logic [PERIOD_LENGTH-1:0] target_q, target_d;
    logic [PW-1:0]            presc_q, presc_d;
    logic [DW-1:0]            dwell_q, dwell_d;
    logic                     at_target_q;

    logic [PERIOD_LENGTH-1:0] half;
    logic [PERIOD_LENGTH-1:0] cmd_target;
    logic                     accept;
    logic                     reversal;
    logic [PERIOD_LENGTH:0]   duty_x, goal_x, step_x, diff_x, delta_x, next_x;
    logic [PERIOD_LENGTH-1:0] step_duty;

    assign half       = period >> 1;
    assign cmd_target = (cmd_duty > period) ? period : cmd_duty;
    assign cmd_ready  = (state_q != DWELL);
    assign accept     = cmd_valid && cmd_ready;
    assign reversal   = ((duty_q > half) && (target_q < half)) ||
                        ((duty_q < half) && (target_q > half));

    // One ramp step toward the goal, widened by a bit so neither direction can wrap or overshoot
    always_comb begin
        duty_x  = {1'b0, duty_q};
        goal_x  = reversal ? {1'b0, half} : {1'b0, target_q};
        step_x  = (step == '0) ? {{PERIOD_LENGTH{1'b0}}, 1'b1} : {1'b0, step};
        diff_x  = (goal_x >= duty_x) ? (goal_x - duty_x) : (duty_x - goal_x);
        delta_x = (step_x < diff_x) ? step_x : diff_x;
        next_x  = (goal_x >= duty_x) ? (duty_x + delta_x) : (duty_x - delta_x);
        step_duty = next_x[PERIOD_LENGTH-1:0];
    end

    // Next-state logic: an accepted command always wins over ramp or dwell progress
    always_comb begin
        state_d  = state_q;
        on_d     = on_q;
        duty_d   = duty_q;
        target_d = target_q;
        presc_d  = presc_q;
        dwell_d  = dwell_q;
        if (accept) begin
            target_d = cmd_target;
            if (!cmd_on) begin
                on_d    = 1'b0;
                duty_d  = half;
                state_d = OFF;
                presc_d = '0;
                dwell_d = '0;
            end else if (state_q == OFF) begin
                on_d    = 1'b1;
                duty_d  = half;
                state_d = RAMP;
                presc_d = '0;
            end else begin
                state_d = RAMP;
            end
        end else begin
            case (state_q)
                OFF: begin
                end
                RAMP: begin
                    if (duty_q == target_q) begin
                        state_d = HOLD;
                    end else if (presc_q == PW'(RAMP_DIV - 1)) begin
                        presc_d = '0;
                        duty_d  = step_duty;
                        if (reversal && (step_duty == half)) begin
                            state_d = DWELL;
                            dwell_d = '0;
                        end else if (step_duty == target_q) begin
                            state_d = HOLD;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                DWELL: begin
                    duty_d = half;
                    on_d   = 1'b1;
                    if (dwell_q == DW'(DWELL_CYCLES - 1)) begin
                        state_d = RAMP;
                        presc_d = '0;
                        dwell_d = '0;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
                HOLD: begin
                end
            endcase
        end
    end

    // State and datapath registers, all cleared asynchronously by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= OFF;
            on_q        <= 1'b0;
            duty_q      <= '0;
            target_q    <= '0;
            presc_q     <= '0;
            dwell_q     <= '0;
            at_target_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            on_q        <= on_d;
            duty_q      <= duty_d;
            target_q    <= target_d;
            presc_q     <= presc_d;
            dwell_q     <= dwell_d;
            at_target_q <= (state_d == HOLD);
        end
    end

    assign on         = on_q;
    assign duty_cycle = duty_q;
    assign at_target  = at_target_q;
    assign state      = state_q;

endmodule

// File: tb/tb_mda_motor_control_ramp_ctrl.sv
// Testbench for mda_motor_control_ramp_ctrl.
// Expected output events (duty/on/state plus the clock gap since the
// previous event) are queued as each command is driven; the DUT's observed
// events are queued as they appear and the two queues are then compared.
module tb_mda_motor_control_ramp_ctrl;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_on;
    logic [15:0] cmd_duty;
    logic [15:0] period;
    logic [15:0] step;
    logic        on;
    logic [15:0] duty_cycle;
    logic        at_target;
    logic [1:0]  state;

    typedef struct packed {
        logic [15:0] duty;
        logic        on;
        logic [1:0]  st;
        logic        rdy;
        logic        at;
        logic [15:0] gap;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];

    int          vectors;
    int          miscompares;
    int          gap_cnt;
    logic [15:0] prev_duty;
    logic        prev_on;
    logic [1:0]  prev_state;

    mda_motor_control_ramp_ctrl #(
        .PERIOD_LENGTH(16),
        .RAMP_DIV(4),
        .DWELL_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_on(cmd_on),
        .cmd_duty(cmd_duty),
        .period(period),
        .step(step),
        .on(on),
        .duty_cycle(duty_cycle),
        .at_target(at_target),
        .state(state)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so a stuck run still ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic ev_t ev(input int d, input int o, input int s, input int g);
        ev_t r;
        r.duty = 16'(d);
        r.on   = 1'(o);
        r.st   = 2'(s);
        r.rdy  = (s != 2);
        r.at   = (s == 3);
        r.gap  = 16'(g);
        return r;
    endfunction

    function automatic string fmt(input ev_t e);
        return $sformatf("duty=%0d on=%0b state=%0d ready=%0b at_target=%0b gap=%0d",
                         e.duty, e.on, e.st, e.rdy, e.at, e.gap);
    endfunction

    task automatic issue(input logic on_i, input logic [15:0] duty_i);
        cmd_valid = 1'b1;
        cmd_on    = on_i;
        cmd_duty  = duty_i;
        gap_cnt   = 0;
    endtask

    task automatic collect(input int n, input int budget);
        int got;
        int cyc;
        ev_t o;
        got = 0;
        cyc = 0;
        while (got < n && cyc < budget) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            cyc++;
            gap_cnt++;
            if (duty_cycle !== prev_duty || on !== prev_on || state !== prev_state) begin
                o.duty = duty_cycle;
                o.on   = on;
                o.st   = state;
                o.rdy  = cmd_ready;
                o.at   = at_target;
                o.gap  = 16'(gap_cnt);
                obs_q.push_back(o);
                prev_duty  = duty_cycle;
                prev_on    = on;
                prev_state = state;
                gap_cnt    = 0;
                got++;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({on, duty_cycle, state, at_target} !== {1'b0, 16'd0, 2'd0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset_hold: on=%0b duty=%0d state=%0d at=%0b, required 0/0/0/0",
                     on, duty_cycle, state, at_target);
        end
        reset_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({on, duty_cycle, state, at_target, cmd_ready} !== {1'b0, 16'd0, 2'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL reset_release: on=%0b duty=%0d state=%0d at=%0b ready=%0b, required 0/0/0/0/1",
                     on, duty_cycle, state, at_target, cmd_ready);
        end
        prev_duty  = 16'd0;
        prev_on    = 1'b0;
        prev_state = 2'd0;
    endtask

    task automatic test_ramp_up();
        ev_t e, o;
        exp_q.push_back(ev(500, 1, 1, 1));
        exp_q.push_back(ev(600, 1, 1, 4));
        exp_q.push_back(ev(700, 1, 1, 4));
        exp_q.push_back(ev(800, 1, 3, 4));
        issue(1'b1, 16'd800);
        collect(4, 100);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL ramp_up: no event observed, required %s", fmt(e));
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    miscompares++;
                    $display("[TB] FAIL ramp_up: got %s, required %s", fmt(o), fmt(e));
                end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_reversal();
        ev_t e, o;
        exp_q.push_back(ev(800, 1, 1, 1));
        exp_q.push_back(ev(700, 1, 1, 4));
        exp_q.push_back(ev(600, 1, 1, 4));
        exp_q.push_back(ev(500, 1, 2, 4));
        exp_q.push_back(ev(500, 1, 1, 8));
        exp_q.push_back(ev(400, 1, 1, 4));
        exp_q.push_back(ev(300, 1, 1, 4));
        exp_q.push_back(ev(200, 1, 3, 4));
        issue(1'b1, 16'd200);
        collect(8, 200);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL reversal: no event observed, required %s", fmt(e));
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    miscompares++;
                    $display("[TB] FAIL reversal: got %s, required %s", fmt(o), fmt(e));
                end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_off_mid_ramp();
        ev_t e, o;
        exp_q.push_back(ev(500, 0, 0, 1));
        exp_q.push_back(ev(500, 1, 1, 1));
        exp_q.push_back(ev(600, 1, 1, 4));
        exp_q.push_back(ev(500, 0, 0, 1));
        issue(1'b0, 16'd0);
        collect(1, 20);
        issue(1'b1, 16'd800);
        collect(2, 40);
        issue(1'b0, 16'd800);
        collect(1, 20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL off_mid_ramp: no event observed, required %s", fmt(e));
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    miscompares++;
                    $display("[TB] FAIL off_mid_ramp: got %s, required %s", fmt(o), fmt(e));
                end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_clamp_no_overshoot();
        ev_t e, o;
        exp_q.push_back(ev(500, 1, 1, 1));
        exp_q.push_back(ev(600, 1, 1, 4));
        exp_q.push_back(ev(700, 1, 1, 4));
        exp_q.push_back(ev(800, 1, 1, 4));
        exp_q.push_back(ev(900, 1, 3, 4));
        exp_q.push_back(ev(900, 1, 1, 1));
        exp_q.push_back(ev(1000, 1, 3, 4));
        issue(1'b1, 16'd900);
        collect(5, 100);
        step = 16'd300;
        issue(1'b1, 16'd1200);
        collect(2, 40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL clamp: no event observed, required %s", fmt(e));
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    miscompares++;
                    $display("[TB] FAIL clamp: got %s, required %s", fmt(o), fmt(e));
                end
            end
        end
        obs_q.delete();
        collect(1, 12);
        vectors++;
        if (obs_q.size() != 0) begin
            o = obs_q.pop_front();
            miscompares++;
            $display("[TB] FAIL clamp_settled: got %s, required no further change", fmt(o));
        end
        obs_q.delete();
    endtask

    task automatic test_step_zero();
        ev_t e, o;
        exp_q.push_back(ev(1000, 1, 1, 1));
        exp_q.push_back(ev(999, 1, 1, 4));
        exp_q.push_back(ev(998, 1, 3, 4));
        step = 16'd0;
        issue(1'b1, 16'd998);
        collect(3, 60);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL step_zero: no event observed, required %s", fmt(e));
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    miscompares++;
                    $display("[TB] FAIL step_zero: got %s, required %s", fmt(o), fmt(e));
                end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_reset_mid_dwell();
        ev_t e, o;
        exp_q.push_back(ev(998, 1, 1, 1));
        exp_q.push_back(ev(698, 1, 1, 4));
        exp_q.push_back(ev(500, 1, 2, 4));
        step = 16'd300;
        issue(1'b1, 16'd300);
        collect(3, 60);
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({on, duty_cycle, state, at_target} !== {1'b0, 16'd0, 2'd0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL async_reset: on=%0b duty=%0d state=%0d at=%0b, required 0/0/0/0",
                     on, duty_cycle, state, at_target);
        end
        @(negedge clk);
        reset_n    = 1'b1;
        prev_duty  = 16'd0;
        prev_on    = 1'b0;
        prev_state = 2'd0;
        step       = 16'd100;
        exp_q.push_back(ev(500, 1, 1, 1));
        exp_q.push_back(ev(600, 1, 3, 4));
        issue(1'b1, 16'd600);
        collect(2, 40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL reset_mid_dwell: no event observed, required %s", fmt(e));
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    miscompares++;
                    $display("[TB] FAIL reset_mid_dwell: got %s, required %s", fmt(o), fmt(e));
                end
            end
        end
        obs_q.delete();
    endtask

    // Test sequence: each scenario leaves the DUT where the next one starts
    initial begin
        vectors     = 0;
        miscompares = 0;
        gap_cnt     = 0;
        reset_n     = 1'b0;
        cmd_valid   = 1'b0;
        cmd_on      = 1'b0;
        cmd_duty    = 16'd0;
        period      = 16'd1000;
        step        = 16'd100;
        prev_duty   = 16'd0;
        prev_on     = 1'b0;
        prev_state  = 2'd0;
        test_reset();
        test_ramp_up();
        test_reversal();
        test_off_mid_ramp();
        test_clamp_no_overshoot();
        test_step_zero();
        test_reset_mid_dwell();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mda_motor_control_ramp_ctrl.md
MDA_MOTOR_CONTROL_RAMP_CTRL -- requirements
Module: mda_motor_control_ramp_ctrl

Interface
REQ-001 SHALL have parameter PERIOD_LENGTH, default 16, width of period/duty buses.
REQ-002 SHALL have parameter RAMP_DIV, default 16000, clocks between ramp steps (min 1).
REQ-003 SHALL have parameter DWELL_CYCLES, default 160000, clocks of brake dwell on direction reversal (min 1).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port cmd_valid  input  1  new command present.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-008 SHALL have port cmd_on  input  1  commanded motor enable.
REQ-009 SHALL have port cmd_duty  input  PERIOD_LENGTH  target duty, centred at period/2 (>half forward, <half reverse, =half brake).
REQ-010 SHALL have port period  input  PERIOD_LENGTH  PWM period, shared with the PWM generator.
REQ-011 SHALL have port step  input  PERIOD_LENGTH  max duty change per ramp step; 0 treated as 1.
REQ-012 SHALL have port on  output  1  registered enable to the PWM generator.
REQ-013 SHALL have port duty_cycle  output  PERIOD_LENGTH  registered duty to the PWM generator.
REQ-014 SHALL have port at_target  output  1  high while in HOLD.
REQ-015 SHALL have port state  output  2  encoded FSM state: OFF=0, RAMP=1, DWELL=2, HOLD=3.

Function
REQ-016 SHALL compute half = period>>1 combinationally every cycle; period changes take effect immediately, with no rescaling of stored values.
REQ-017 SHALL latch target = min(cmd_duty, period) on handshake.
REQ-018 SHALL drive cmd_ready=1 in OFF, RAMP and HOLD, and 0 in DWELL.
REQ-019 SHALL, on an accepted command with cmd_on=0 in any state, next cycle: on=0, duty_cycle=half, state OFF, prescaler cleared.
REQ-020 SHALL, on an accepted command with cmd_on=1 while in OFF, next cycle: on=1, duty_cycle=half, state RAMP, prescaler cleared.
REQ-021 SHALL, on an accepted command with cmd_on=1 in RAMP or HOLD, replace the target and enter RAMP without clearing the prescaler or changing duty_cycle that cycle.
REQ-022 SHALL, in RAMP, count the prescaler 0..RAMP_DIV-1 and apply one ramp step on the cycle it wraps.
REQ-023 SHALL form each ramp step as duty_cycle moving toward the step goal by min(step, |goal-duty_cycle|), with PERIOD_LENGTH+1-bit arithmetic: no overshoot, no wrap-around.
REQ-024 SHALL set the step goal to half when a reversal is pending (duty_cycle>half and target<half, or duty_cycle<half and target>half), and to target otherwise.
REQ-025 SHALL enter DWELL on the cycle duty_cycle reaches half with a reversal pending, hold duty_cycle=half and on=1 (brake) for exactly DWELL_CYCLES clocks, then return to RAMP with the prescaler cleared.
REQ-026 SHALL enter HOLD when duty_cycle equals target in RAMP, and stay in HOLD until a new command arrives.
REQ-027 SHALL give a command accepted in the same cycle as a ramp step priority over that step.
REQ-028 SHALL drive state and at_target directly from registers.

Reset
REQ-029 SHALL, while reset_n=0, asynchronously force on=0, duty_cycle=0, state=OFF, at_target=0, target=0, prescaler=0, dwell counter=0.
REQ-030 SHALL drive cmd_ready=1 from the first clock after reset_n deasserts.
REQ-031 SHALL abort any ramp or dwell when reset is asserted mid-operation, with no residual state.

Verification (period=1000, step=100, RAMP_DIV=4, DWELL_CYCLES=8)
REQ-032 SHALL cover: reset -> on=0, duty_cycle=0, state=0, cmd_ready=1.
REQ-033 SHALL cover: cmd on/800 from OFF -> duty_cycle 500 next cycle, then 600, 700, 800 at 4-clock intervals, then state=3 and at_target=1.
REQ-034 SHALL cover: from HOLD@800, cmd on/200 -> 700, 600, 500; DWELL 8 clocks with on=1, cmd_ready=0; then 400, 300, 200; then HOLD.
REQ-035 SHALL cover: cmd off during RAMP at 600 -> next cycle on=0, duty_cycle=500, state=0.
REQ-036 SHALL cover: cmd_duty=1200 with step=300 from HOLD@900 -> target 1000, a single step to 1000, no overshoot.
REQ-037 SHALL cover: reset_n low mid-DWELL, asynchronous to clk -> outputs at reset values before the next clock edge.
